// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider: one shift/subtract/restore step per clock over a WIDTH+1 bit partial remainder.
// Latency: done pulses WIDTH+3 cycles after start is accepted (2 cycles for a zero divisor).
// Backpressure: none; start is sampled only in IDLE, and requests arriving while busy are dropped (not queued).
//
// Ports:
//   clock, clear       rising-edge clock, asynchronous active-low reset
//   start, signed_op   request pulse and signed(DIV)/unsigned(DIVU) select, sampled in IDLE
//   dividend, divisor  operands, latched with start
//   busy, done         busy from PREP through DONE; done is a one-cycle result-valid pulse
//   div_by_zero        set with done for a zero divisor, held until the next accepted start
//   quotient           LO result, held until the next request completes
//   remainder          HI result, held until the next request completes
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    logic             op_signed;
    logic [WIDTH-1:0] op_dividend;
    logic [WIDTH-1:0] op_divisor;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CW-1:0]    count;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] q_fixed;
    logic [WIDTH-1:0] r_fixed;

    always_comb begin
        dvd_neg = op_signed & op_dividend[WIDTH-1];
        dvs_neg = op_signed & op_divisor[WIDTH-1];
        // Magnitudes are unsigned WIDTH-bit, so |-2^(W-1)| = 2^(W-1) fits.
        dvd_abs = dvd_neg ? (~op_dividend + ONE) : op_dividend;
        dvs_abs = dvs_neg ? (~op_divisor + ONE) : op_divisor;
        // Partial remainder stays below M, so the shifted value fits in WIDTH+1 bits
        // and the MSB of the difference is a clean borrow flag.
        shifted = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        diff    = shifted - {1'b0, m_reg};
        // Quotient sign follows operand sign mismatch; remainder takes dividend sign.
        q_fixed = (dvd_neg ^ dvs_neg) ? (~q_reg + ONE) : q_reg;
        r_fixed = dvd_neg ? (~a_reg[WIDTH-1:0] + ONE) : a_reg[WIDTH-1:0];
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            op_signed   <= 1'b0;
            op_dividend <= '0;
            op_divisor  <= '0;
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            count       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_signed   <= signed_op;
                        op_dividend <= dividend;
                        op_divisor  <= divisor;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        state       <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (op_divisor == '0) begin
                        // Zero divisor skips iteration; results land for the DONE cycle.
                        quotient    <= '1;
                        remainder   <= op_dividend;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        q_reg <= dvd_abs;
                        m_reg <= dvs_abs;
                        a_reg <= '0;
                        count <= '0;
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    // Borrow clear: keep the difference and set the quotient bit;
                    // borrow set: restore (keep shifted value) and clear the bit.
                    a_reg <= diff[WIDTH] ? shifted : diff;
                    q_reg <= {q_reg[WIDTH-2:0], ~diff[WIDTH]};
                    count <= count + CW'(1);
                    if (count == LAST_STEP) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    quotient  <= q_fixed;
                    remainder <= r_fixed;
                    done      <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomized checks of div_sequencer against an arithmetic reference model.
// Latency: each request is tracked cycle by cycle from its accepted start to done.
// Backpressure: exercises start while busy (ignored) and reset mid-operation.
module tb_div_sequencer;

    logic        clock;
    logic        clear;
    logic        start;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] prev_q = 32'd0;
    logic [31:0] prev_r = 32'd0;

    div_sequencer #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: magnitudes divided with wide integer arithmetic, then signs applied
    // (quotient negative on sign mismatch, remainder follows the dividend).
    task automatic model(input logic sop, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dbz,
                         output int lat);
        longint sa, sb, ma, mb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dbz = 1'b1; lat = 2;
        end else begin
            sa = sop ? longint'($signed(a)) : longint'(a);
            sb = sop ? longint'($signed(b)) : longint'(b);
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            lq = ma / mb;
            lr = ma % mb;
            if ((sa < 0) != (sb < 0)) lq = -lq;
            if (sa < 0) lr = -lr;
            q = lq[31:0]; r = lr[31:0]; dbz = 1'b0; lat = 35;
        end
    endtask

    // Holds start for one cycle, then scrambles operands to prove they were latched.
    // Returns at cycle 1 (the first cycle after the accepting edge).
    task automatic start_req(input logic sop, input logic [31:0] a, input logic [31:0] b);
        @(posedge clock); #1;
        start = 1'b1; signed_op = sop; dividend = a; divisor = b;
        @(posedge clock); #1;
        start = 1'b0;
        signed_op = 1'($urandom);
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    task automatic finish_req(input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                              input int elat, input string tag);
        int cyc;
        cyc = 1;
        check({tag, "_busy_c1"}, 64'(busy), 64'd1);
        check({tag, "_dbz_clr_c1"}, 64'(div_by_zero), 64'd0);
        check({tag, "_q_hold_c1"}, 64'(quotient), 64'(prev_q));
        while (done !== 1'b1 && cyc < elat + 10) begin
            @(posedge clock); #1;
            cyc++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(elat));
        check({tag, "_busy_done"}, 64'(busy), 64'd1);
        check({tag, "_quotient"}, 64'(quotient), 64'(eq));
        check({tag, "_remainder"}, 64'(remainder), 64'(er));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(edbz));
        prev_q = eq;
        prev_r = er;
        @(posedge clock); #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_q_hold"}, 64'(quotient), 64'(eq));
        check({tag, "_dbz_hold"}, 64'(div_by_zero), 64'(edbz));
    endtask

    initial begin
        logic [31:0] rq, rr, ra, rb;
        logic        rdbz, rs;
        int          rlat, cyc;

        clear = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        check("rst_q", 64'(quotient), 64'd0);
        check("rst_r", 64'(remainder), 64'd0);
        clear = 1'b1;

        // Basic unsigned and signed directed cases
        start_req(1'b0, 32'd100, 32'd7);
        finish_req(32'd14, 32'd2, 1'b0, 35, "u100_7");
        start_req(1'b1, 32'hFFFF_FF9C, 32'd7);
        finish_req(32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 35, "sneg100_7");
        start_req(1'b1, 32'd100, 32'hFFFF_FFF9);
        finish_req(32'hFFFF_FFF2, 32'd2, 1'b0, 35, "s100_neg7");

        // Divide by zero, then a valid request clears the flag (checked at cycle 1)
        start_req(1'b0, 32'hDEAD_BEEF, 32'd0);
        finish_req(32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 2, "dbz");
        start_req(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_req(32'h8000_0000, 32'd0, 1'b0, 35, "sovf");
        start_req(1'b0, 32'hFFFF_FFFF, 32'd1);
        finish_req(32'hFFFF_FFFF, 32'd0, 1'b0, 35, "umax_1");

        // start while busy (ITER and DONE) is ignored; start in IDLE accepted
        start_req(1'b0, 32'd1000, 32'd9);
        cyc = 1;
        while (cyc < 35) begin
            if (cyc == 5) begin
                start = 1'b1; dividend = 32'd77; divisor = 32'd5;
            end else if (cyc == 6) begin
                start = 1'b0;
            end
            @(posedge clock); #1;
            cyc++;
        end
        check("busy_ign_done35", 64'(done), 64'd1);
        check("busy_ign_q", 64'(quotient), 64'd111);
        check("busy_ign_r", 64'(remainder), 64'd1);
        prev_q = 32'd111;
        prev_r = 32'd1;
        start = 1'b1; signed_op = 1'b0; dividend = 32'd12345; divisor = 32'd0;
        start_req(1'b0, 32'd500, 32'd7);
        finish_req(32'd71, 32'd3, 1'b0, 35, "after_ign");

        // Reset mid-ITER clears everything at once; a new request then runs normally
        start_req(1'b1, 32'hFFFF_FF9C, 32'd7);
        cyc = 1;
        while (cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        clear = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_dbz", 64'(div_by_zero), 64'd0);
        check("mid_rst_q", 64'(quotient), 64'd0);
        check("mid_rst_r", 64'(remainder), 64'd0);
        @(posedge clock); #1;
        clear = 1'b1;
        prev_q = 32'd0;
        prev_r = 32'd0;
        start_req(1'b0, 32'd9, 32'd3);
        finish_req(32'd3, 32'd0, 1'b0, 35, "post_rst");

        // Randomized requests against the reference model
        for (int i = 0; i < 30; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = $urandom;
                1:       rb = $urandom_range(1, 20);
                2:       rb = 32'(-int'($urandom_range(1, 20)));
                3:       rb = 32'd0;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            model(rs, ra, rb, rq, rr, rdbz, rlat);
            start_req(rs, ra, rb);
            finish_req(rq, rr, rdbz, rlat, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
